// File: rtl/comparator_pulser_checker.sv
// Test-pulse injector and readout checker for the comparator front end.
// Define COMPARATOR_PULSER_BURST_EN to fire num_pulses+1 pulses per request.
module comparator_pulser_checker #(
  parameter int NHS     = 32,
  parameter int CNT_W   = 32,
  parameter int PW_W    = 4,
  parameter int DLY_W   = 4,
  parameter int TIMEOUT = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fire_pulse,
  input  logic [PW_W-1:0]  i_pulse_width,
  input  logic [DLY_W-1:0] i_bx_delay,
  input  logic [7:0]       i_num_pulses,
  input  logic             i_compin_inject,
  input  logic [NHS-1:0]   i_halfstrips,
  input  logic [NHS-1:0]   i_halfstrips_expect,
  input  logic [NHS-1:0]   i_active_strip_mask,
  input  logic             i_compout,
  input  logic             i_compout_expect,
  input  logic [3:0]       i_errcnt_rst,
  output logic             o_pulser_ready,
  output logic             o_pulse_en,
  output logic             o_compin,
  output logic [NHS-1:0]   o_halfstrips_ff,
  output logic [CNT_W-1:0] o_thresholds_errcnt,
  output logic [CNT_W-1:0] o_halfstrips_errcnt,
  output logic [CNT_W-1:0] o_compout_errcnt,
  output logic [CNT_W-1:0] o_timeout_errcnt,
  output logic [7:0]       o_pulses_done
);

  localparam int PD_W = (PW_W > DLY_W) ? PW_W : DLY_W;
  localparam int CW   = (PD_W > 8) ? PD_W : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_PULSING, S_DELAY, S_READOUT, S_REARM
  } state_t;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_pulses_done;
  logic [NHS-1:0] r_halfstrips_ff;
  logic [CNT_W-1:0] r_thr_cnt, r_hs_cnt, r_co_cnt, r_to_cnt;
  logic w_trigger, w_timeout, w_ro_exit, w_more;
  logic w_thr_inc, w_hs_inc, w_co_inc, w_to_inc;

  assign w_trigger = |i_halfstrips;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ro_exit = (r_state == S_READOUT) && (w_trigger || w_timeout);

`ifdef COMPARATOR_PULSER_BURST_EN
  assign w_more = (r_pulses_done < i_num_pulses);
`else
  logic w_unused_num_pulses;
  assign w_unused_num_pulses = ^i_num_pulses;
  assign w_more = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_fire_pulse) w_next = S_PULSING;
      S_PULSING: if (r_cnt == CW'(i_pulse_width)) w_next = S_DELAY;
      S_DELAY:   if (r_cnt == CW'(i_bx_delay)) w_next = S_READOUT;
      S_READOUT: if (w_ro_exit) w_next = w_more ? S_PULSING : S_REARM;
      S_REARM:   if (!i_fire_pulse) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The cycle counter restarts on every state change and idles at zero outside timed states.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_PULSING || r_state == S_DELAY || r_state == S_READOUT)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // A trigger is judged against the expected pattern; a timeout only expects silence.
  assign w_thr_inc = w_ro_exit && w_trigger && |(i_halfstrips & ~i_active_strip_mask);
  assign w_hs_inc  = w_ro_exit && (w_trigger ? (i_halfstrips != i_halfstrips_expect)
                                             : (i_halfstrips_expect != '0));
  assign w_co_inc  = w_ro_exit && w_trigger && (i_compout != i_compout_expect);
  assign w_to_inc  = w_ro_exit && !w_trigger;

  function automatic logic [CNT_W-1:0] f_cnt_next(input logic [CNT_W-1:0] v,
                                                  input logic clr, input logic inc);
    if (clr) return '0;
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pulses_done   <= '0;
      r_halfstrips_ff <= '0;
      r_thr_cnt       <= '0;
      r_hs_cnt        <= '0;
      r_co_cnt        <= '0;
      r_to_cnt        <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_PULSING)
        r_pulses_done <= '0;
      else if (w_ro_exit)
        r_pulses_done <= r_pulses_done + 8'd1;
      if (w_trigger)
        r_halfstrips_ff <= i_halfstrips;
      r_thr_cnt <= f_cnt_next(r_thr_cnt, i_errcnt_rst[0], w_thr_inc);
      r_hs_cnt  <= f_cnt_next(r_hs_cnt,  i_errcnt_rst[1], w_hs_inc);
      r_co_cnt  <= f_cnt_next(r_co_cnt,  i_errcnt_rst[2], w_co_inc);
      r_to_cnt  <= f_cnt_next(r_to_cnt,  i_errcnt_rst[3], w_to_inc);
    end
  end

  assign o_pulser_ready      = (r_state == S_IDLE);
  assign o_pulse_en          = (r_state == S_PULSING);
  assign o_compin            = o_pulse_en & i_compin_inject;
  assign o_halfstrips_ff     = r_halfstrips_ff;
  assign o_thresholds_errcnt = r_thr_cnt;
  assign o_halfstrips_errcnt = r_hs_cnt;
  assign o_compout_errcnt    = r_co_cnt;
  assign o_timeout_errcnt    = r_to_cnt;
  assign o_pulses_done       = r_pulses_done;

endmodule

// File: tb/tb_comparator_pulser_checker.sv
// Directed bench for comparator_pulser_checker with a scoreboard of expected readout results.
module tb_comparator_pulser_checker;

  localparam int NHS = 32;
  localparam int CNT_W = 2;
  localparam int TIMEOUT = 20;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic fire_pulse;
  logic [3:0] pulse_width;
  logic [3:0] bx_delay;
  logic [7:0] num_pulses;
  logic compin_inject;
  logic [NHS-1:0] halfstrips, halfstrips_expect, active_strip_mask;
  logic compout, compout_expect;
  logic [3:0] errcnt_rst;
  logic pulser_ready, pulse_en, compin;
  logic [NHS-1:0] halfstrips_ff;
  logic [CNT_W-1:0] thr_cnt, hs_cnt, co_cnt, to_cnt;
  logic [7:0] pulses_done;

  comparator_pulser_checker #(
    .NHS(NHS), .CNT_W(CNT_W), .PW_W(4), .DLY_W(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fire_pulse(fire_pulse),
    .i_pulse_width(pulse_width), .i_bx_delay(bx_delay), .i_num_pulses(num_pulses),
    .i_compin_inject(compin_inject), .i_halfstrips(halfstrips),
    .i_halfstrips_expect(halfstrips_expect), .i_active_strip_mask(active_strip_mask),
    .i_compout(compout), .i_compout_expect(compout_expect), .i_errcnt_rst(errcnt_rst),
    .o_pulser_ready(pulser_ready), .o_pulse_en(pulse_en), .o_compin(compin),
    .o_halfstrips_ff(halfstrips_ff), .o_thresholds_errcnt(thr_cnt),
    .o_halfstrips_errcnt(hs_cnt), .o_compout_errcnt(co_cnt), .o_timeout_errcnt(to_cnt),
    .o_pulses_done(pulses_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] thr, hs, co, to, hsff;
    logic [7:0]  pd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int mThr = 0, mHs = 0, mCo = 0, mTo = 0;
  logic [31:0] mHsff = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] pw, input logic [3:0] dly,
                               input logic [31:0] hs, input logic [31:0] ex,
                               input logic [31:0] mask, input logic co, input logic coex,
                               input logic inj);
    pulse_width = pw;
    bx_delay = dly;
    halfstrips = hs;
    halfstrips_expect = ex;
    active_strip_mask = mask;
    compout = co;
    compout_expect = coex;
    compin_inject = inj;
  endtask

  function automatic int satStep(input int v, input logic clr, input logic inc);
    if (clr) return 0;
    if (inc && v < MAXC) return v + 1;
    return v;
  endfunction

  // Reference model of one READOUT exit using the currently driven inputs.
  task automatic modelExit(input logic [3:0] clr);
    logic trig;
    trig = (halfstrips != 0);
    if (trig) begin
      mThr = satStep(mThr, clr[0], (halfstrips & ~active_strip_mask) != 0);
      mHs  = satStep(mHs,  clr[1], halfstrips != halfstrips_expect);
      mCo  = satStep(mCo,  clr[2], compout != compout_expect);
      mTo  = satStep(mTo,  clr[3], 1'b0);
      mHsff = halfstrips;
    end else begin
      mThr = satStep(mThr, clr[0], 1'b0);
      mHs  = satStep(mHs,  clr[1], halfstrips_expect != 0);
      mCo  = satStep(mCo,  clr[2], 1'b0);
      mTo  = satStep(mTo,  clr[3], 1'b1);
    end
  endtask

  task automatic pushExpect(input int pd);
    exp_t e;
    e.thr = 32'(mThr); e.hs = 32'(mHs); e.co = 32'(mCo); e.to = 32'(mTo);
    e.hsff = mHsff; e.pd = 8'(pd);
    sb.push_back(e);
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_thr"},  64'(thr_cnt), 64'(e.thr));
    checkOutput({tag, "_hs"},   64'(hs_cnt),  64'(e.hs));
    checkOutput({tag, "_co"},   64'(co_cnt),  64'(e.co));
    checkOutput({tag, "_to"},   64'(to_cnt),  64'(e.to));
    checkOutput({tag, "_hsff"}, 64'(halfstrips_ff), 64'(e.hsff));
    checkOutput({tag, "_pd"},   64'(pulses_done), 64'(e.pd));
  endtask

  // Raises fire_pulse and watches the sequence until pulses_done reaches expPulses.
  task automatic fireAndWait(input string tag, input int expPulses,
                             output int highs, output int rises,
                             output int cinHighs, output int tail);
    int firstFall;
    logic prev;
    logic ok;
    firstFall = -1; prev = 1'b0; ok = 1'b0;
    highs = 0; rises = 0; cinHighs = 0; tail = -1;
    fire_pulse = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pulse_en) begin
        highs++;
        if (!prev) rises++;
      end else if (prev && firstFall < 0) begin
        firstFall = i;
      end
      if (compin) cinHighs++;
      prev = pulse_en;
      if (rises > 0 && !pulse_en && pulses_done == 8'(expPulses)) begin
        tail = i - firstFall + 1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput({tag, "_done_wait"}, 64'd0, 64'd1);
  endtask

  task automatic endSeq(input string tag);
    fire_pulse = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ready"}, 64'(pulser_ready), 64'd1);
  endtask

  int highs, rises, cinHighs, tail, expP;

  initial begin
    rst_n = 1'b0;
    fire_pulse = 1'b0;
    num_pulses = 8'd0;
    errcnt_rst = 4'd0;
    applyStimulus(4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",  64'(pulser_ready), 64'd1);
    checkOutput("rst_pulse",  64'(pulse_en), 64'd0);
    checkOutput("rst_compin", 64'(compin), 64'd0);
    checkOutput("rst_hsff",   64'(halfstrips_ff), 64'd0);
    checkOutput("rst_cnts",   64'({thr_cnt, hs_cnt, co_cnt, to_cnt}), 64'd0);
    checkOutput("rst_pd",     64'(pulses_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single pulse with matching trigger");
    applyStimulus(4'd3, 4'd2, 32'h10, 32'h10, 32'hF0, 1'b1, 1'b1, 1'b1);
    modelExit(4'd0);
    pushExpect(1);
    fireAndWait("single", 1, highs, rises, cinHighs, tail);
    checkOutput("single_width", 64'(highs), 64'd4);
    checkOutput("single_rises", 64'(rises), 64'd1);
    checkOutput("single_compin", 64'(cinHighs), 64'd4);
    checkOutput("single_tail", 64'(tail), 64'(3 + 1 + 1));
    popCompare("match");
    repeat (2) begin
      @(negedge clk);
      checkOutput("rearm_hold", 64'(pulser_ready), 64'd0);
    end
    endSeq("single");

    $display("[TB] mismatching trigger");
    applyStimulus(4'd1, 4'd1, 32'h101, 32'h100, 32'h100, 1'b0, 1'b1, 1'b1);
    modelExit(4'd0);
    pushExpect(1);
    fireAndWait("mism", 1, highs, rises, cinHighs, tail);
    popCompare("mism");
    endSeq("mism");

    $display("[TB] readout timeout");
    applyStimulus(4'd0, 4'd0, 32'h0, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    modelExit(4'd0);
    pushExpect(1);
    fireAndWait("tmo", 1, highs, rises, cinHighs, tail);
    checkOutput("tmo_width", 64'(highs), 64'd1);
    checkOutput("tmo_tail", 64'(tail), 64'(1 + TIMEOUT + 1));
    popCompare("tmo");
    repeat (3) begin
      @(negedge clk);
      checkOutput("tmo_rearm_hold", 64'(pulser_ready), 64'd0);
    end
    endSeq("tmo");

    $display("[TB] burst request");
`ifdef COMPARATOR_PULSER_BURST_EN
    expP = 3;
`else
    expP = 1;
`endif
    num_pulses = 8'd2;
    applyStimulus(4'd2, 4'd1, 32'h10, 32'h10, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < expP; i++) modelExit(4'd0);
    pushExpect(expP);
    fireAndWait("burst", expP, highs, rises, cinHighs, tail);
    checkOutput("burst_rises", 64'(rises), 64'(expP));
    checkOutput("burst_highs", 64'(highs), 64'(3 * expP));
    checkOutput("burst_compin", 64'(cinHighs), 64'd0);
    popCompare("burst");
    endSeq("burst");
    num_pulses = 8'd0;

    $display("[TB] saturation");
    applyStimulus(4'd0, 4'd0, 32'h101, 32'h100, 32'h100, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      modelExit(4'd0);
      pushExpect(1);
      fireAndWait("sat", 1, highs, rises, cinHighs, tail);
      popCompare("sat");
      endSeq("sat");
    end
    checkOutput("sat_hs_allones", 64'(hs_cnt), 64'(MAXC));
    checkOutput("sat_thr_allones", 64'(thr_cnt), 64'(MAXC));

    $display("[TB] clear with same-cycle increment");
    fire_pulse = 1'b1;
    @(negedge clk);
    checkOutput("clr_pulse_en", 64'(pulse_en), 64'd1);
    @(negedge clk);
    @(negedge clk);
    errcnt_rst = 4'b0101;
    modelExit(4'b0101);
    pushExpect(1);
    @(negedge clk);
    errcnt_rst = 4'b0000;
    popCompare("clrinc");
    endSeq("clrinc");

    $display("[TB] idle clear of halfstrips and timeout counters");
    errcnt_rst = 4'b1010;
    @(negedge clk);
    errcnt_rst = 4'b0000;
    checkOutput("idleclr_hs", 64'(hs_cnt), 64'd0);
    checkOutput("idleclr_to", 64'(to_cnt), 64'd0);
    checkOutput("idleclr_co", 64'(co_cnt), 64'(mCo));

    $display("[TB] asynchronous reset during pulse");
    applyStimulus(4'd15, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    fire_pulse = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("arst_before", 64'(pulse_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_pulse_en", 64'(pulse_en), 64'd0);
    checkOutput("arst_compin", 64'(compin), 64'd0);
    checkOutput("arst_ready", 64'(pulser_ready), 64'd1);
    checkOutput("arst_pd", 64'(pulses_done), 64'd0);
    checkOutput("arst_thr", 64'(thr_cnt), 64'd0);
    fire_pulse = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_pulser_checker.md
# comparator_pulser_checker

Parametrised pulse injector and readout checker for comparator test firmware. It fires a programmable-width test pulse, or a burst of pulses, into the comparator front end, waits a programmable bunch-crossing delay, then opens a readout window. In that window it checks the returned halfstrip pattern and the compout bit against expectations. It sits between the slow-control register file, which supplies configuration and reads counters, and the triad decoder, which supplies `halfstrips`.

## Interface
Parameters:
- `NHS`, 32, halfstrip vector width
- `CNT_W`, 32, width of every error/event counter
- `PW_W`, 4, width of `pulse_width`
- `DLY_W`, 4, width of `bx_delay`
- `TIMEOUT`, 20, readout window length in cycles; legal range 1..255

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fire_pulse`  in  1  level request to start a pulse sequence
- `pulse_width`  in  PW_W  pulse length minus one, in cycles
- `bx_delay`  in  DLY_W  delay between pulse end and readout, minus one, in cycles
- `num_pulses`  in  8  burst length minus one (burst build only)
- `compin_inject`  in  1  gates `compin` during the pulse
- `halfstrips`  in  NHS  live halfstrip hits from the triad decoder
- `halfstrips_expect`  in  NHS  expected halfstrip pattern
- `active_strip_mask`  in  NHS  strips allowed to fire
- `compout`, `compout_expect`  in  1  comparator output and its expected value
- `errcnt_rst`  in  4  synchronous clears: [0] thresholds, [1] halfstrips, [2] compout, [3] timeout
- `pulser_ready`  out  1  state is IDLE
- `pulse_en`  out  1  state is PULSING
- `compin`  out  1  `pulse_en & compin_inject`
- `halfstrips_ff`  out  NHS  last non-zero `halfstrips`
- `thresholds_errcnt`, `halfstrips_errcnt`, `compout_errcnt`, `timeout_errcnt`  out  CNT_W  error counters
- `pulses_done`  out  8  pulses completed in the current or last sequence

## Operation
- FSM states: IDLE, PULSING, DELAY, READOUT, REARM. One cycle-counter is cleared on every state change.
- IDLE → PULSING when `fire_pulse`=1. On this transition `pulses_done` clears to 0.
- PULSING → DELAY when count == `pulse_width`.
- DELAY → READOUT when count == `bx_delay`.
- READOUT → next state on `trigger` (`|halfstrips`) or on timeout (count == TIMEOUT-1). `pulses_done` increments on this exit. The next state is PULSING if more pulses remain in the burst, else REARM.
- REARM → IDLE when `fire_pulse`=0. This prevents retrigger on a held level.
- Checks apply only on the READOUT exit cycle:
  - On trigger:
    - `thresholds_errcnt`+1 if `(halfstrips & ~active_strip_mask) != 0`
    - `halfstrips_errcnt`+1 if `halfstrips != halfstrips_expect`
    - `compout_errcnt`+1 if `compout != compout_expect`
  - On timeout:
    - `timeout_errcnt`+1
    - `halfstrips_errcnt`+1 if `halfstrips_expect != 0`
- All counters saturate at all-ones; they never wrap.
- A clear bit takes priority over a same-cycle increment of that counter.
- `halfstrips_ff` loads `halfstrips` on any cycle with `trigger`=1, in any state.
- Parameter/configuration inputs are sampled live. Software must change them only while `pulser_ready`=1.

## Timing
- Reset values:
  - state IDLE, so `pulser_ready`=1, `pulse_en`=0, `compin`=0
  - all counters 0
  - `halfstrips_ff`=0
  - `pulses_done`=0
- `rst_n` asserted mid-sequence aborts immediately (asynchronous); `pulse_en` drops without waiting for a clock edge.
- Cycle latencies:
  - `pulse_en` rises one cycle after `fire_pulse` is sampled high.
  - `pulse_en` is high for `pulse_width`+1 cycles.
  - DELAY lasts `bx_delay`+1 cycles.
  - READOUT lasts 1..TIMEOUT cycles.
- Counter updates and `pulses_done` are visible one cycle after the READOUT exit edge.
- If trigger and timeout occur together, the trigger wins; `timeout_errcnt` is not incremented.
- `pulse_width` and `bx_delay` at maximum (all-ones) must not wrap the cycle counter. The counter is max(PW_W, DLY_W, 8) bits wide.

## Configuration
- Macro `COMPARATOR_PULSER_BURST_EN`:
  - Defined: READOUT returns to PULSING while `pulses_done` < `num_pulses`, giving `num_pulses`+1 pulses per `fire_pulse`.
  - Undefined: `num_pulses` is ignored and READOUT always goes to REARM, so exactly one pulse per `fire_pulse` and `pulses_done` ends at 1.

## Test plan
- **Single pulse:** reset; `pulse_width`=3, `bx_delay`=2, `fire_pulse` 1 → `pulse_en` high 4 cycles, then 3 DELAY cycles.
- **Matching trigger:** in READOUT, drive `halfstrips`=`halfstrips_expect`=0x00000010, mask=0x000000F0, `compout`=`compout_expect` → all error counters stay 0 and `halfstrips_ff`=0x00000010.
- **Mismatches:** trigger with `halfstrips`=0x00000101, expect=0x00000100, mask=0x00000100, `compout`≠expect → thresholds, halfstrips and compout counters each = 1.
- **Timeout:** no hits, expect=0x1 → after exactly TIMEOUT=20 READOUT cycles, `timeout_errcnt`=1, `halfstrips_errcnt`=1, state REARM until `fire_pulse` is 0.
- **Burst (macro defined):** `num_pulses`=2 → three `pulse_en` pulses and `pulses_done`=3. Macro undefined → one pulse and `pulses_done`=1.
- **Saturation, clear and reset:** preload a counter to all-ones, then trigger an error → it holds all-ones. Clear with an increment in the same cycle → 0. `rst_n` low during PULSING → `pulse_en`=0 immediately and `pulser_ready`=1.
